// File: rtl/Key_Scheduler.sv
// Single AES-128 key-schedule round: derives the next round key from the
// current one. Bit 127 is the MSB of byte 0; RCON[31:24] is the round constant.
module Key_Scheduler (
  input  logic [127:0] Key,
  input  logic [31:0]  RCON,
  output logic [127:0] k
);

  localparam int unsigned WORD_W = 32;

  // AES forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset 8*(255-x); 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  logic [WORD_W-1:0] w3_rot;
  logic [WORD_W-1:0] w3_sub;
  logic [WORD_W-1:0] temp;
  logic [WORD_W-1:0] k0;
  logic [WORD_W-1:0] k1;
  logic [WORD_W-1:0] k2;
  logic [WORD_W-1:0] k3;

  // RotWord/SubWord on the last word, then the XOR ripple across the four words.
  always_comb begin
    w3_rot = {Key[23:0], Key[31:24]};
    w3_sub = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
              sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])};
    temp   = w3_sub ^ RCON;
    k0     = Key[127:96] ^ temp;
    k1     = Key[95:64]  ^ k0;
    k2     = Key[63:32]  ^ k1;
    k3     = Key[31:0]   ^ k2;
    k      = {k0, k1, k2, k3};
  end

endmodule

// File: rtl/key_expansion_ctrl.sv
// Sequential AES-128 key expansion: one schedule round per clock, all eleven
// round keys kept in a register file behind a registered read port.
module key_expansion_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:127] Key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_addr,
  output logic [0:127] rd_key
);

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned RCON_W     = 8;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned NUM_RK     = 11;
  localparam int unsigned LAST_ROUND = 10;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_EXPAND = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [ROUND_W-1:0] round_q,     round_d;
  logic [RCON_W-1:0]  rcon_q,      rcon_d;
  logic [KEY_W-1:0]   cur_key_q,   cur_key_d;
  logic [KEY_W-1:0]   rk_q [NUM_RK];
  logic [KEY_W-1:0]   rk_d [NUM_RK];
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               key_valid_q, key_valid_d;
  logic [KEY_W-1:0]   rd_key_q,    rd_key_d;

  logic [KEY_W-1:0]   ks_k;
  logic [RCON_W-1:0]  rcon_next;

  Key_Scheduler u_key_scheduler (
    .Key  (cur_key_q),
    .RCON ({rcon_q, 24'h000000}),
    .k    (ks_k)
  );

  // GF(2^8) doubling of the round constant.
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);

  // Next-state, storage update and read-port selection.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rcon_d      = rcon_q;
    cur_key_d   = cur_key_q;
    rk_d        = rk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_valid_d = key_valid_q;
    rd_key_d    = '0;

    // Addresses 11..15 match no entry and read as zero.
    for (int i = 0; i < NUM_RK; i++) begin
      if (rd_addr == ROUND_W'(i)) rd_key_d = rk_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_d[0]     = Key_in;
          cur_key_d   = Key_in;
          round_d     = ROUND_W'(1);
          rcon_d      = 8'h01;
          key_valid_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int i = 1; i < NUM_RK; i++) begin
          if (round_q == ROUND_W'(i)) rk_d[i] = ks_k;
        end
        cur_key_d = ks_k;
        rcon_d    = rcon_next;
        round_d   = round_q + ROUND_W'(1);
        if (round_q == ROUND_W'(LAST_ROUND)) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and storage registers; reset wipes every stored key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      rcon_q      <= '0;
      cur_key_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      rd_key_q    <= '0;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      rcon_q      <= rcon_d;
      cur_key_q   <= cur_key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_valid_q <= key_valid_d;
      rd_key_q    <= rd_key_d;
      for (int i = 0; i < NUM_RK; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl: known-answer table, corner-case sequences and
// random keys against an arithmetic AES-128 key-schedule model.
module tb_key_expansion_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] Key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_addr;
  logic [0:127] rd_key;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];

  typedef struct {
    logic [127:0] key;
    int           addr;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [8];

  key_expansion_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Key_in    (Key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key)
  );

  always #5 clk = ~clk;

  // Compare helper.
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] a   = 8'(v);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      if (a != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, a);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[v] = s;
    end
  endtask

  // Word-level FIPS-197 key expansion into model_rk.
  task automatic compute_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Registered read: address before the edge, data sampled on the next falling edge.
  task automatic read_key(input int addr, output logic [127:0] data);
    rd_addr = 4'(addr);
    @(negedge clk);
    data = rd_key;
  endtask

  // Pulse start and count edges until done (bounded); returns edges after the accepting edge.
  task automatic run_expand(input logic [127:0] key, output int lat);
    start  = 1'b1;
    Key_in = key;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_all_keys(input string name, input logic [127:0] key);
    logic [127:0] d;
    compute_model(key);
    for (int a = 0; a < 11; a++) begin
      read_key(a, d);
      check($sformatf("%s_rk%0d", name, a), d, model_rk[a]);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] key_a;
    logic [127:0] key_b;
    logic [7:0]   rcon_seq [10];
    int           lat;

    rcon_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[4] = '{128'h0, 0,  128'h0};
    vecs[5] = '{128'h0, 1,  128'h62636363626363636263636362636363};
    vecs[6] = '{128'h0, 2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    vecs[7] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();
    rst_n   = 1'b0;
    start   = 1'b0;
    Key_in  = '0;
    rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy",      128'(busy),      128'h0);
    check("reset_done",      128'(done),      128'h0);
    check("reset_key_valid", 128'(key_valid), 128'h0);
    check("reset_rd_key",    rd_key,          128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 A.1 with round-constant monitoring and done-pulse width.
    key_a  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start  = 1'b1;
    Key_in = key_a;
    @(negedge clk);
    start = 1'b0;
    check("fips_busy_rise", 128'(busy), 128'h1);
    lat = 0;
    while (!done && lat < 30) begin
      if (lat < 10) check($sformatf("rcon_round%0d", lat + 1), 128'(dut.rcon_q), 128'(rcon_seq[lat]));
      @(negedge clk);
      lat++;
    end
    check("fips_latency",   128'(lat),       128'd10);
    check("fips_busy_fall", 128'(busy),      128'h0);
    check("fips_key_valid", 128'(key_valid), 128'h1);
    @(negedge clk);
    check("fips_done_pulse", 128'(done), 128'h0);
    check_all_keys("fips", key_a);

    // Known-answer table.
    for (int i = 0; i < 8; i++) begin
      run_expand(vecs[i].key, lat);
      check($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
      read_key(vecs[i].addr, d);
      check($sformatf("kat%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end

    // A start during expansion is ignored.
    key_a  = {$urandom, $urandom, $urandom, $urandom};
    key_b  = ~key_a;
    start  = 1'b1;
    Key_in = key_a;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      if (lat == 3) begin
        start  = 1'b1;
        Key_in = key_b;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("ignored_start_latency", 128'(lat), 128'd10);
    check_all_keys("ignored_start", key_a);

    // Back-to-back: zero key accepted on the done cycle.
    key_a = {$urandom, $urandom, $urandom, $urandom};
    run_expand(key_a, lat);
    check("b2b_first_latency", 128'(lat), 128'd10);
    start  = 1'b1;
    Key_in = '0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_key_valid_drop", 128'(key_valid), 128'h0);
    check("b2b_busy",           128'(busy),      128'h1);
    lat = 0;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", 128'(lat), 128'd10);
    read_key(10, d);
    check("b2b_rk10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Reset in the middle of an expansion.
    key_a = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    run_expand(key_a, lat);
    rd_addr = 4'd0;
    start   = 1'b1;
    Key_in  = key_a;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy",      128'(busy),      128'h0);
    check("rst_mid_key_valid", 128'(key_valid), 128'h0);
    check("rst_mid_rd_key",    rd_key,          128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 11; a++) begin
      read_key(a, d);
      check($sformatf("rst_mid_rk%0d", a), d, 128'h0);
    end
    key_a = {$urandom, $urandom, $urandom, $urandom};
    run_expand(key_a, lat);
    check("post_rst_latency", 128'(lat), 128'd10);
    check_all_keys("post_rst", key_a);

    // Out-of-range addresses read as zero.
    for (int a = 11; a < 16; a++) begin
      read_key(a, d);
      check($sformatf("oor_addr%0d", a), d, 128'h0);
    end

    // Random keys against the model.
    for (int n = 0; n < 12; n++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      run_expand(key_a, lat);
      check($sformatf("rand%0d_latency", n), 128'(lat), 128'd10);
      check($sformatf("rand%0d_key_valid", n), 128'(key_valid), 128'h1);
      check_all_keys($sformatf("rand%0d", n), key_a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
